// File: rtl/n4_pkg.sv
// n4 convolution datapath shared parameters and helpers.
// Window geometry used by the window generator and the MAC array.
package n4_pkg;

  localparam int N4_WIDTH = 16;
  localparam int N4_IMG_W = 28;
  localparam int N4_IMG_H = 28;
  localparam int N4_K     = 5;

  // Flat element index of window position (r,c).
  function automatic int win_idx(
    input int r,
    input int c,
    input int k = N4_K
  );
    return r * k + c;
  endfunction

endpackage

// File: rtl/n4_line_buf.sv
// n4 line buffer: single-port circular RAM, read-before-write.
// Read is combinational so a chain of buffers shifts in one beat.
module n4_line_buf #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 28,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk) begin
    if (en_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/n4_window_gen.sv
// n4 streaming KxK sliding-window generator.
// Raster pixels in, one full in-image window per accepted beat out.
module n4_window_gen
  import n4_pkg::*;
#(
  parameter int WIDTH = N4_WIDTH,
  parameter int IMG_W = N4_IMG_W,
  parameter int IMG_H = N4_IMG_H,
  parameter int K     = N4_K
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     din,
  input  logic                 din_valid,
  output logic [K*K*WIDTH-1:0] window,
  output logic                 win_valid,
  output logic                 frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0]        col_q, col_d;
  logic [RW-1:0]        row_q, row_d;
  logic [K*K*WIDTH-1:0] win_q, win_d;
  logic                 wv_q, wv_d;
  logic                 fd_q, fd_d;
  logic                 last_col;
  logic                 last_row;

  logic [WIDTH-1:0] lb_rd [K-1];
  logic [WIDTH-1:0] lb_wr [K-1];
  logic [WIDTH-1:0] newcol [K];

  genvar gi;
  generate
    for (gi = 0; gi < K-1; gi++) begin : g_lb
      if (gi == 0) begin : g_head
        assign lb_wr[gi] = din;
      end else begin : g_tail
        assign lb_wr[gi] = lb_rd[gi-1];
      end

      n4_line_buf #(
        .WIDTH (WIDTH),
        .DEPTH (IMG_W),
        .AW    (CW)
      ) u_lb (
        .clk     (clk),
        .en_i    (din_valid),
        .addr_i  (col_q),
        .wdata_i (lb_wr[gi]),
        .rdata_o (lb_rd[gi])
      );
    end
  endgenerate

  // Buffer i holds the row i+1 above the current one.
  always_comb begin
    for (int r = 0; r < K; r++) begin
      newcol[r] = din;
    end
    for (int r = 0; r < K-1; r++) begin
      newcol[r] = lb_rd[K-2-r];
    end
  end

  assign last_col = (col_q == CW'(IMG_W-1));
  assign last_row = (row_q == RW'(IMG_H-1));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    win_d = win_q;
    wv_d  = 1'b0;
    fd_d  = 1'b0;
    if (din_valid) begin
      col_d = last_col ? '0 : col_q + 1'b1;
      if (last_col) begin
        row_d = last_row ? '0 : row_q + 1'b1;
      end
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K-1; c++) begin
          win_d[win_idx(r, c, K)*WIDTH +: WIDTH] =
            win_q[win_idx(r, c+1, K)*WIDTH +: WIDTH];
        end
        win_d[win_idx(r, K-1, K)*WIDTH +: WIDTH] = newcol[r];
      end
      wv_d = (row_q >= RW'(K-1)) && (col_q >= CW'(K-1));
      fd_d = last_col && last_row;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
      win_q <= '0;
      wv_q  <= 1'b0;
      fd_q  <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      win_q <= win_d;
      wv_q  <= wv_d;
      fd_q  <= fd_d;
    end
  end

  assign window     = win_q;
  assign win_valid  = wv_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_n4_window_gen.sv
// n4_window_gen bench: 8x8/K=3 and default 28x28/K=5 instances
// compared against a frame-image reference model.
module tb_n4_window_gen;

  logic clk;
  logic rst_n;

  logic [15:0]  din_s, din_b;
  logic         dv_s, dv_b;
  logic [143:0] win_s;
  logic [399:0] win_b;
  logic         wv_s, wv_b, fd_s, fd_b;

  n4_window_gen #(
    .WIDTH (16),
    .IMG_W (8),
    .IMG_H (8),
    .K     (3)
  ) u_small (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din_s),
    .din_valid  (dv_s),
    .window     (win_s),
    .win_valid  (wv_s),
    .frame_done (fd_s)
  );

  n4_window_gen u_big (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din_b),
    .din_valid  (dv_b),
    .window     (win_b),
    .win_valid  (wv_b),
    .frame_done (fd_b)
  );

  always #5 clk = ~clk;

  int n_chk;
  int n_err;

  int sel;
  int mw, mh, mk;
  int mrow, mcol;
  int nwin, nfd;
  bit held;
  logic [15:0]  img [28][28];
  logic [399:0] e_win;

  task automatic chk(input string tag,
                     input logic [399:0] got,
                     input logic [399:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic set_dut(input int s);
    sel  = s;
    mw   = s ? 28 : 8;
    mh   = s ? 28 : 8;
    mk   = s ? 5 : 3;
    mrow = 0;
    mcol = 0;
    held = 0;
  endtask

  task automatic beat(input bit v, input logic [15:0] p);
    bit e_wv, e_fd;
    logic [399:0] ow;
    if (sel == 0) begin
      din_s = p;
      dv_s  = v;
    end else begin
      din_b = p;
      dv_b  = v;
    end
    @(posedge clk);
    #1;
    dv_s = 0;
    dv_b = 0;
    e_wv = 0;
    e_fd = 0;
    if (v) begin
      img[mrow][mcol] = p;
      e_wv = (mrow >= mk-1) && (mcol >= mk-1);
      e_fd = (mrow == mh-1) && (mcol == mw-1);
      held = e_wv;
      if (e_wv) begin
        e_win = '0;
        for (int r = 0; r < mk; r++)
          for (int c = 0; c < mk; c++)
            e_win[(r*mk+c)*16 +: 16] = img[mrow-mk+1+r][mcol-mk+1+c];
      end
      if (mcol == mw-1) begin
        mcol = 0;
        mrow = (mrow == mh-1) ? 0 : mrow + 1;
      end else begin
        mcol++;
      end
    end
    ow = sel ? win_b : 400'(win_s);
    chk("win_valid", 400'(sel ? wv_b : wv_s), 400'(e_wv));
    chk("frame_done", 400'(sel ? fd_b : fd_s), 400'(e_fd));
    if (held) chk(v ? "window" : "window_hold", ow, e_win);
    if (sel ? wv_b : wv_s) nwin++;
    if (sel ? fd_b : fd_s) nfd++;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_win_s"}, 400'(win_s), '0);
    chk({tag, "_win_b"}, win_b, '0);
    chk({tag, "_flags"}, 400'({wv_s, fd_s, wv_b, fd_b}), '0);
  endtask

  // mode 0: ramp, always valid; 1: ramp, 1-0-0 valid; 2: random
  task automatic run_frame(input int mode);
    logic [15:0] pix;
    nwin = 0;
    nfd  = 0;
    for (int i = 0; i < mw*mh; i++) begin
      pix = (mode == 2) ? 16'($urandom) : 16'(i);
      if (mode == 2)
        while ($urandom_range(0, 3) == 0) beat(0, 16'($urandom));
      beat(1, pix);
      if (mode == 1) begin
        beat(0, 16'hdead);
        beat(0, 16'hbeef);
      end
    end
    chk("windows_per_frame", 400'(nwin), 400'((mw-mk+1)*(mh-mk+1)));
    chk("frame_done_count", 400'(nfd), 400'(1));
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    chk_zero("async_rst");
    @(posedge clk);
    #1;
    chk_zero("held_rst");
    rst_n = 1;
    mrow = 0;
    mcol = 0;
    held = 0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    clk   = 0;
    rst_n = 0;
    dv_s  = 0;
    dv_b  = 0;
    din_s = 0;
    din_b = 0;
    #3;
    chk_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1;

    set_dut(0);
    run_frame(0);
    run_frame(1);
    run_frame(2);
    run_frame(2);
    for (int i = 0; i < 31; i++) beat(1, 16'(i));
    do_reset();
    run_frame(0);
    run_frame(2);

    set_dut(1);
    run_frame(0);
    chk("last_elem_44", 400'(e_win[24*16 +: 16]), 400'(783));
    run_frame(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
